// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the instruction-cache to DDR3 read bridge.
package dram_arb_pkg;

  localparam int LINE_AW = 23;
  localparam int DDR_AW  = 28;
  localparam int DATA_W  = 128;
  localparam int XID_W   = 2;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT) + 1;

  localparam logic [2:0] DDR_CMD_RD = 3'b001;
  localparam logic [2:0] DDR_CMD_WR = 3'b000;

  typedef logic [XID_W-1:0]   xid_t;
  typedef logic [DATA_W-1:0]  line_t;
  typedef logic [LINE_AW-1:0] line_addr_t;
  typedef logic [DDR_AW-1:0]  ddr_addr_t;
  typedef logic [CNT_W-1:0]   out_cnt_t;

  // A line address covers bits [26:4]; the byte offset within the line is always zero.
  function automatic ddr_addr_t line_to_ddr(input line_addr_t line_addr);
    return {1'b0, line_addr, 4'b0000};
  endfunction

endpackage

// File: rtl/ic_dram_arb_if.sv
// Instruction-cache line-fill port: request (ic -> memory) and response (memory -> ic).
interface ic_dram_arb_if;
  import dram_arb_pkg::*;

  line_addr_t ic_mem_addr;
  xid_t       ic_mem_xid;
  logic       ic_mem_re;
  logic       mem_ic_ready;
  logic       mem_ic_valid;
  xid_t       mem_xxx_xid;
  line_t      mem_xxx_data;

  modport master (
    output ic_mem_addr, ic_mem_xid, ic_mem_re,
    input  mem_ic_ready, mem_ic_valid, mem_xxx_xid, mem_xxx_data
  );

  modport slave (
    input  ic_mem_addr, ic_mem_xid, ic_mem_re,
    output mem_ic_ready, mem_ic_valid, mem_xxx_xid, mem_xxx_data
  );

endinterface

// File: rtl/ic_dram_xid_fifo.sv
// Small synchronous FIFO holding the xids of outstanding DDR reads in issue order.
module ic_dram_xid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule

// File: rtl/ic_dram_arb.sv
// Bridges the i-cache line-fill port to the DDR3 user interface (reads only).
// Define DRAM_ARB_ERR_EN to add the sticky arb_err protocol-error output.
module ic_dram_arb
  import dram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ic_dram_arb_if.slave     ic,
  input  logic             ddr_calib_done,
  output logic [2:0]       ddr_cmd,
  output logic             ddr_cmd_en,
  output ddr_addr_t        ddr_addr,
  input  logic             ddr_cmd_ready,
  output line_t            ddr_wr_data,
  output logic [15:0]      ddr_wr_data_mask,
  output logic             ddr_wr_data_en,
  input  line_t            ddr_rd_data,
  input  logic             ddr_rd_data_valid
`ifdef DRAM_ARB_ERR_EN
  ,
  output logic             arb_err
`endif
);

  logic     accept;
  logic     push;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;
  out_cnt_t fifo_count;
  xid_t     fifo_head;
  logic     rsp_valid;
  xid_t     rsp_xid;
  line_t    rsp_data;

  ic_dram_xid_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (XID_W)
  ) u_xid_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ic.ic_mem_xid),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The command path is purely combinational so a request issues in the cycle it is accepted.
  assign accept     = ddr_calib_done & ddr_cmd_ready & (fifo_count < out_cnt_t'(MAX_OUT));
  assign push       = ic.ic_mem_re & accept;
  assign pop        = ddr_rd_data_valid & ~fifo_empty;

  assign ic.mem_ic_ready = accept;
  assign ddr_cmd_en      = push;
  assign ddr_cmd         = DDR_CMD_RD;
  assign ddr_addr        = line_to_ddr(ic.ic_mem_addr);

  assign ddr_wr_data      = '0;
  assign ddr_wr_data_mask = '0;
  assign ddr_wr_data_en   = 1'b0;

  // A beat with no outstanding xid has no owner and is dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_xid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_xid  <= fifo_head;
        rsp_data <= ddr_rd_data;
      end
    end
  end

  assign ic.mem_ic_valid = rsp_valid;
  assign ic.mem_xxx_xid  = rsp_xid;
  assign ic.mem_xxx_data = rsp_data;

`ifdef DRAM_ARB_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((ddr_rd_data_valid & fifo_empty) | (ic.ic_mem_re & fifo_full)) begin
      err_q <= 1'b1;
    end
  end

  assign arb_err = err_q;
`endif

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    (fifo_full |-> !ddr_cmd_en));
  a_read_only: assert property (@(posedge clk) disable iff (rst) ddr_cmd != DDR_CMD_WR);

endmodule

// File: tb/tb_ic_dram_arb.sv
// Directed, table-driven bench for ic_dram_arb (works with or without DRAM_ARB_ERR_EN).
module tb_ic_dram_arb;
  import dram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ddr_calib_done;
  logic [2:0]  ddr_cmd;
  logic        ddr_cmd_en;
  ddr_addr_t   ddr_addr;
  logic        ddr_cmd_ready;
  line_t       ddr_wr_data;
  logic [15:0] ddr_wr_data_mask;
  logic        ddr_wr_data_en;
  line_t       ddr_rd_data;
  logic        ddr_rd_data_valid;
`ifdef DRAM_ARB_ERR_EN
  logic        arb_err;
`endif

  int checks   = 0;
  int failures = 0;

  ic_dram_arb_if ic_bus ();

  ic_dram_arb dut (
    .clk               (clk),
    .rst               (rst),
    .ic                (ic_bus),
    .ddr_calib_done    (ddr_calib_done),
    .ddr_cmd           (ddr_cmd),
    .ddr_cmd_en        (ddr_cmd_en),
    .ddr_addr          (ddr_addr),
    .ddr_cmd_ready     (ddr_cmd_ready),
    .ddr_wr_data       (ddr_wr_data),
    .ddr_wr_data_mask  (ddr_wr_data_mask),
    .ddr_wr_data_en    (ddr_wr_data_en),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_rd_data_valid (ddr_rd_data_valid)
`ifdef DRAM_ARB_ERR_EN
    ,
    .arb_err           (arb_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       calib;
    logic       cmd_rdy;
    logic       re;
    line_addr_t addr;
    xid_t       xid;
    logic       rvalid;
    line_t      rdata;
    logic       exp_ready;
    logic       exp_en;
    logic       exp_valid;
    xid_t       exp_xid;
    line_t      exp_data;
    logic       exp_err;
  } vec_t;

  localparam int NV = 20;
  localparam line_t DEAD = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D;

  vec_t vecs [NV];

  function automatic line_t pat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic vec_t mk(input logic c, input logic r, input logic re, input line_addr_t a,
                              input xid_t x, input logic rv, input line_t d, input logic e_rdy,
                              input logic e_en, input logic e_v, input xid_t e_x,
                              input line_t e_d, input logic e_err);
    vec_t v;
    v.calib = c;  v.cmd_rdy = r;  v.re = re;  v.addr = a;  v.xid = x;
    v.rvalid = rv;  v.rdata = d;
    v.exp_ready = e_rdy;  v.exp_en = e_en;  v.exp_valid = e_v;
    v.exp_xid = e_x;  v.exp_data = e_d;  v.exp_err = e_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ddr_calib_done     = v.calib;
    ddr_cmd_ready      = v.cmd_rdy;
    ic_bus.ic_mem_re   = v.re;
    ic_bus.ic_mem_addr = v.addr;
    ic_bus.ic_mem_xid  = v.xid;
    ddr_rd_data_valid  = v.rvalid;
    ddr_rd_data        = v.rdata;
  endtask

  task automatic checkErr(input string name, input logic req);
`ifdef DRAM_ARB_ERR_EN
    checkOutput(name, 128'(arb_err), 128'(req));
`else
    if (req === 1'bx) $display("[TB] unexpected unknown in %s", name);
`endif
  endtask

  initial begin
    // Fields: calib, cmd_rdy, re, addr, xid, rvalid, rdata | ready, cmd_en, valid, xid, data, err
    vecs[0]  = mk(0, 0, 1, 23'h091A2B, 1, 0, '0,      0, 0, 0, 0, '0,      0);
    vecs[1]  = mk(0, 1, 1, 23'h091A2B, 1, 0, '0,      0, 0, 0, 0, '0,      0);
    vecs[2]  = mk(1, 1, 1, 23'h091A2B, 1, 0, '0,      1, 1, 0, 0, '0,      0);
    vecs[3]  = mk(1, 1, 0, 23'h091A2B, 1, 1, DEAD,    1, 0, 1, 1, DEAD,    0);
    vecs[4]  = mk(1, 1, 0, 23'h091A2B, 1, 0, '0,      1, 0, 0, 0, '0,      0);
    vecs[5]  = mk(1, 1, 0, 23'h000010, 0, 1, pat(99), 1, 0, 0, 0, '0,      1);
    vecs[6]  = mk(1, 0, 1, 23'h000100, 0, 0, '0,      0, 0, 0, 0, '0,      1);
    vecs[7]  = mk(1, 1, 1, 23'h000100, 0, 0, '0,      1, 1, 0, 0, '0,      1);
    vecs[8]  = mk(1, 1, 1, 23'h000200, 1, 0, '0,      1, 1, 0, 0, '0,      1);
    vecs[9]  = mk(1, 1, 1, 23'h000300, 2, 0, '0,      1, 1, 0, 0, '0,      1);
    vecs[10] = mk(1, 1, 1, 23'h000400, 3, 0, '0,      1, 1, 0, 0, '0,      1);
    vecs[11] = mk(1, 1, 1, 23'h000500, 0, 0, '0,      0, 0, 0, 0, '0,      1);
    vecs[12] = mk(1, 1, 1, 23'h000500, 0, 1, pat(0),  0, 0, 1, 0, pat(0),  1);
    vecs[13] = mk(1, 1, 1, 23'h000500, 0, 1, pat(1),  1, 1, 1, 1, pat(1),  1);
    vecs[14] = mk(1, 1, 0, 23'h000500, 0, 1, pat(2),  1, 0, 1, 2, pat(2),  1);
    vecs[15] = mk(1, 1, 0, 23'h000500, 0, 1, pat(3),  1, 0, 1, 3, pat(3),  1);
    vecs[16] = mk(1, 1, 0, 23'h000500, 0, 1, pat(4),  1, 0, 1, 0, pat(4),  1);
    vecs[17] = mk(1, 1, 0, 23'h000500, 0, 1, pat(5),  1, 0, 0, 0, '0,      1);
    vecs[18] = mk(1, 1, 1, 23'h000700, 3, 0, '0,      1, 1, 0, 0, '0,      1);
    vecs[19] = mk(1, 1, 0, 23'h000700, 3, 1, pat(6),  1, 0, 1, 3, pat(6),  1);

    rst = 1'b1;
    applyStimulus(mk(0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
    #12;
    checkOutput("reset valid", 128'(ic_bus.mem_ic_valid), 128'(0));
    checkOutput("reset xid", 128'(ic_bus.mem_xxx_xid), 128'(0));
    checkOutput("reset data", ic_bus.mem_xxx_data, 128'(0));
    checkOutput("reset cmd", 128'(ddr_cmd), 128'(3'b001));
    checkOutput("reset ready", 128'(ic_bus.mem_ic_ready), 128'(0));
    checkOutput("reset cmd_en", 128'(ddr_cmd_en), 128'(0));
    checkOutput("wr tie-offs", {ddr_wr_data[111:0], ddr_wr_data_mask}, 128'(0));
    checkOutput("wr_data_en", 128'(ddr_wr_data_en), 128'(0));
    checkErr("reset err", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d ready", i), 128'(ic_bus.mem_ic_ready), 128'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d cmd_en", i), 128'(ddr_cmd_en), 128'(vecs[i].exp_en));
      checkOutput($sformatf("v%0d ddr_addr", i), 128'(ddr_addr),
                  128'({1'b0, vecs[i].addr, 4'h0}));
      checkOutput($sformatf("v%0d cmd", i), 128'(ddr_cmd), 128'(3'b001));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d valid", i), 128'(ic_bus.mem_ic_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d rsp_xid", i), 128'(ic_bus.mem_xxx_xid), 128'(vecs[i].exp_xid));
        checkOutput($sformatf("v%0d rsp_data", i), ic_bus.mem_xxx_data, vecs[i].exp_data);
      end
      checkErr($sformatf("v%0d err", i), vecs[i].exp_err);
    end

    // Spot-check the documented address mapping independently of the table formula.
    @(negedge clk);
    applyStimulus(mk(1, 1, 0, 23'h091A2B, 1, 0, '0, 1, 0, 0, 0, '0, 1));
    #1;
    checkOutput("addr map", 128'(ddr_addr), 128'(28'h091A2B0));

    // Reset with two reads still outstanding: the FIFO must be flushed.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(mk(1, 1, 1, 23'h000800 + 23'(k), xid_t'(k + 1), 0, '0, 1, 1, 0, 0, '0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    applyStimulus(mk(1, 1, 0, 23'h000800, 0, 1, pat(10), 1, 0, 1, 1, pat(10), 1));
    @(posedge clk);
    #1;
    checkOutput("pre-rst valid", 128'(ic_bus.mem_ic_valid), 128'(1));
    checkOutput("pre-rst xid", 128'(ic_bus.mem_xxx_xid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid-rst valid", 128'(ic_bus.mem_ic_valid), 128'(0));
    checkOutput("mid-rst xid", 128'(ic_bus.mem_xxx_xid), 128'(0));
    checkOutput("mid-rst data", ic_bus.mem_xxx_data, 128'(0));
    checkOutput("mid-rst ready", 128'(ic_bus.mem_ic_ready), 128'(1));
    checkErr("mid-rst err", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ddr_rd_data = pat(11);
    @(posedge clk);
    #1;
    checkOutput("post-rst beat1 dropped", 128'(ic_bus.mem_ic_valid), 128'(0));
    checkErr("post-rst err", 1'b1);
    @(negedge clk);
    ddr_rd_data = pat(12);
    @(posedge clk);
    #1;
    checkOutput("post-rst beat2 dropped", 128'(ic_bus.mem_ic_valid), 128'(0));

    // Normal traffic resumes after the flush.
    @(negedge clk);
    applyStimulus(mk(1, 1, 1, 23'h000900, 2, 0, '0, 1, 1, 0, 0, '0, 1));
    #1;
    checkOutput("resume cmd_en", 128'(ddr_cmd_en), 128'(1));
    @(posedge clk);
    @(negedge clk);
    applyStimulus(mk(1, 1, 0, 23'h000900, 2, 1, pat(13), 1, 0, 1, 2, pat(13), 1));
    @(posedge clk);
    #1;
    checkOutput("resume valid", 128'(ic_bus.mem_ic_valid), 128'(1));
    checkOutput("resume xid", 128'(ic_bus.mem_xxx_xid), 128'(2));
    checkOutput("resume data", ic_bus.mem_xxx_data, pat(13));

    @(negedge clk);
    ddr_rd_data_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
